// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: default queue geometry and the fetch entry
// record reused by the pipeline-register stages after decode.
package fetch_pkg;

    localparam int FQ_DEPTH = 4;
    localparam int FQ_IW    = 16;
    localparam int FQ_AW    = 16;

    typedef struct packed {
        logic [FQ_IW-1:0] instr;
        logic [FQ_AW-1:0] pc_plus_1;
    } fetch_entry_t;

    function automatic fetch_entry_t make_fetch_entry(
        input logic [FQ_IW-1:0] instr,
        input logic [FQ_AW-1:0] pc_plus_1
    );
        fetch_entry_t e;
        e.instr     = instr;
        e.pc_plus_1 = pc_plus_1;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Register-array storage for the fetch queue: one synchronous write port and
// one asynchronous read port. Contents are never reset; validity lives in the pointers.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [PW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [PW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// First-word-fall-through instruction buffer between fetch and decode.
// Holds {instr, pc_plus_1} pairs in order and raises fetch_stall when full.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int IW    = FQ_IW,
    parameter int AW    = FQ_AW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IW-1:0]              instr_in,
    input  logic [AW-1:0]              pc_plus_1_in,
    input  logic                       fetch_valid,
    input  logic                       flush,
    output logic                       fetch_stall,
    output logic [IW-1:0]              instr_out,
    output logic [AW-1:0]              pc_plus_1_out,
    output logic                       out_valid,
    input  logic                       dec_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [IW+AW-1:0] w_wdata;
    logic [IW+AW-1:0] w_rdata;

    // Handshake: an entry moves into the queue when fetch_valid is high and the
    // queue is not full; it leaves when out_valid and dec_ready are both high.
    // flush overrides both and empties the queue at the same edge.
    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_push  = fetch_valid & ~w_full & ~flush;
    assign w_pop   = ~w_empty & dec_ready & ~flush;
    assign w_wdata = {instr_in, pc_plus_1_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .W     (IW + AW),
        .PW    (PW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Stale storage is masked so decode sees zeros whenever the queue is empty.
    assign fetch_stall   = w_full;
    assign out_valid     = ~w_empty;
    assign instr_out     = w_empty ? '0 : w_rdata[IW+AW-1:AW];
    assign pc_plus_1_out = w_empty ? '0 : w_rdata[AW-1:0];
    assign count         = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: one task per scenario with inline checks.
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr_in;
  logic [15:0] pc_plus_1_in;
  logic        fetch_valid;
  logic        flush;
  logic        fetch_stall;
  logic [15:0] instr_out;
  logic [15:0] pc_plus_1_out;
  logic        out_valid;
  logic        dec_ready;
  logic [2:0]  count;

  int checks;
  int failures;

  fetch_queue #(.DEPTH(4), .IW(16), .AW(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_in      (instr_in),
    .pc_plus_1_in  (pc_plus_1_in),
    .fetch_valid   (fetch_valid),
    .flush         (flush),
    .fetch_stall   (fetch_stall),
    .instr_out     (instr_out),
    .pc_plus_1_out (pc_plus_1_out),
    .out_valid     (out_valid),
    .dec_ready     (dec_ready),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    instr_in = '0; pc_plus_1_in = '0; fetch_valid = 1'b0; flush = 1'b0; dec_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || fetch_stall !== 1'b0 ||
        instr_out !== 16'h0 || pc_plus_1_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_init: count=%0d valid=%b stall=%b instr=%h pc=%h, need 0/0/0/0000/0000",
               count, out_valid, fetch_stall, instr_out, pc_plus_1_out);
    end
    step();
    rst_n = 1'b1;
    // Fill three entries, then assert reset between edges.
    for (int i = 0; i < 3; i++) begin
      instr_in = 16'hF001 + 16'(i);
      pc_plus_1_in = 16'h0F01 + 16'(i);
      fetch_valid = 1'b1;
      step();
    end
    fetch_valid = 1'b0;
    checks++;
    if (count !== 3'd3 || instr_out !== 16'hF001) begin
      failures++;
      $display("FAIL reset_prefill: count=%0d instr=%h, need 3/F001", count, instr_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || fetch_stall !== 1'b0 ||
        instr_out !== 16'h0 || pc_plus_1_out !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid: count=%0d valid=%b stall=%b instr=%h pc=%h, need 0/0/0/0000/0000",
               count, out_valid, fetch_stall, instr_out, pc_plus_1_out);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_fill_stall();
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      instr_in = 16'hA001 + 16'(i);
      pc_plus_1_in = 16'h0001 + 16'(i);
      fetch_valid = 1'b1;
      step();
      checks++;
      if (count !== 3'(i + 1) || fetch_stall !== (i == 3)) begin
        failures++;
        $display("FAIL fill_%0d: count=%0d stall=%b, need %0d/%b", i, count, fetch_stall, i + 1, i == 3);
      end
    end
    // Fifth word presented while full must be refused.
    instr_in = 16'hA005;
    pc_plus_1_in = 16'h0005;
    step();
    checks++;
    if (count !== 3'd4 || fetch_stall !== 1'b1 || instr_out !== 16'hA001 || pc_plus_1_out !== 16'h0001) begin
      failures++;
      $display("FAIL fill_refuse: count=%0d stall=%b instr=%h pc=%h, need 4/1/A001/0001",
               count, fetch_stall, instr_out, pc_plus_1_out);
    end
  endtask

  task automatic test_drain();
    logic [15:0] exp_head [5];
    logic [2:0]  exp_cnt [5];
    exp_head = '{16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'h0000};
    exp_cnt  = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      // A005 stays presented until the cycle it is accepted (edge 2).
      if (i == 1) fetch_valid = 1'b0;
      checks++;
      if (instr_out !== exp_head[i] || count !== exp_cnt[i] || fetch_stall !== 1'b0 ||
          out_valid !== (exp_cnt[i] != 3'd0)) begin
        failures++;
        $display("FAIL drain_%0d: instr=%h count=%0d stall=%b valid=%b, need %h/%0d/0/%b",
                 i, instr_out, count, fetch_stall, out_valid, exp_head[i], exp_cnt[i], exp_cnt[i] != 3'd0);
      end
    end
  endtask

  task automatic test_push_pop();
    dec_ready = 1'b0;
    fetch_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      instr_in = 16'hD000 + 16'(i);
      pc_plus_1_in = 16'h0100 + 16'(i);
      step();
    end
    checks++;
    if (count !== 3'd2 || instr_out !== 16'hD000) begin
      failures++;
      $display("FAIL pp_setup: count=%0d instr=%h, need 2/D000", count, instr_out);
    end
    dec_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      instr_in = 16'hD000 + 16'(k + 1);
      pc_plus_1_in = 16'h0100 + 16'(k + 1);
      step();
      checks++;
      if (count !== 3'd2 || instr_out !== 16'hD000 + 16'(k) || pc_plus_1_out !== 16'h0100 + 16'(k)) begin
        failures++;
        $display("FAIL pp_%0d: count=%0d instr=%h pc=%h, need 2/%h/%h",
                 k, count, instr_out, pc_plus_1_out, 16'hD000 + 16'(k), 16'h0100 + 16'(k));
      end
    end
  endtask

  task automatic test_flush();
    dec_ready = 1'b0;
    instr_in = 16'hE000;
    pc_plus_1_in = 16'h0E01;
    fetch_valid = 1'b1;
    step();
    checks++;
    if (count !== 3'd3 || instr_out !== 16'hD00A) begin
      failures++;
      $display("FAIL flush_setup: count=%0d instr=%h, need 3/D00A", count, instr_out);
    end
    flush = 1'b1;
    dec_ready = 1'b1;
    instr_in = 16'hE001;
    pc_plus_1_in = 16'h0E02;
    step();
    flush = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || fetch_stall !== 1'b0 ||
        instr_out !== 16'h0 || pc_plus_1_out !== 16'h0) begin
      failures++;
      $display("FAIL flush_clear: count=%0d valid=%b stall=%b instr=%h pc=%h, need 0/0/0/0000/0000",
               count, out_valid, fetch_stall, instr_out, pc_plus_1_out);
    end
    dec_ready = 1'b0;
    instr_in = 16'hB000;
    pc_plus_1_in = 16'h0B01;
    step();
    fetch_valid = 1'b0;
    checks++;
    if (count !== 3'd1 || out_valid !== 1'b1 || instr_out !== 16'hB000 || pc_plus_1_out !== 16'h0B01) begin
      failures++;
      $display("FAIL flush_refetch: count=%0d valid=%b instr=%h pc=%h, need 1/1/B000/0B01",
               count, out_valid, instr_out, pc_plus_1_out);
    end
    dec_ready = 1'b1;
    step();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_alone: count=%0d valid=%b, need 0/0", count, out_valid);
    end
  endtask

  task automatic test_empty_push();
    instr_in = 16'hC0DE;
    pc_plus_1_in = 16'h0C0E;
    fetch_valid = 1'b1;
    dec_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || instr_out !== 16'h0) begin
      failures++;
      $display("FAIL empty_nobypass: valid=%b instr=%h, need 0/0000", out_valid, instr_out);
    end
    step();
    fetch_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || instr_out !== 16'hC0DE || pc_plus_1_out !== 16'h0C0E || count !== 3'd1) begin
      failures++;
      $display("FAIL empty_visible: valid=%b instr=%h pc=%h count=%0d, need 1/C0DE/0C0E/1",
               out_valid, instr_out, pc_plus_1_out, count);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL empty_popped: valid=%b count=%0d, need 0/0", out_valid, count);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fill_stall();
    test_drain();
    test_push_pop();
    test_flush();
    test_empty_push();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
